slave_msg_packer: RTL and testbench
===================================

Name: slave_msg_packer

Overview:
- Sits directly downstream of the slave-side functional blocks (func_testing and siblings).
- Round-robin arbitrates their have_msg_bus requests and drains up to MAX_LEN bytes from the granted source through rdreq_bus / slave data.
- Frames the drained bytes into a packet and streams it byte-wise to the PC link transmitter over a valid/ready handshake.
- Packet format: 0xAA, addr, len, payload[len], csum. csum = XOR of addr, len and all payload bytes.

Parameters:
- N_SRC, 5, number of message sources (bit i of the buses = address i).
- MAX_LEN, 16, max payload bytes per packet (1..255).

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- have_msg_bus  in  N_SRC  source i has at least one byte to read.
- slave_data_bus  in  8*N_SRC  byte of source i at bits [8i+7:8i]; valid exactly 1 cycle after its rdreq (non-show-ahead FIFO).
- rdreq_bus  out  N_SRC  read strobe per source; one-hot or zero.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready.
- busy  out  1  high in any state other than IDLE.
- pkt_done  out  1  one-cycle pulse on the cycle the csum byte is accepted.

Behaviour:
- Reset: state=IDLE; rdreq_bus=0, tx_valid=0, tx_data=0, busy=0, pkt_done=0; rr pointer last=N_SRC-1, so source 0 has first priority; byte counters=0.
- States: IDLE, GATHER, SOF, ADDR, LEN, PAYLOAD, CSUM.
- IDLE:
  - If any have_msg_bus bit is set, grant the first set index searching last+1, last+2, ... modulo N_SRC.
  - Latch sel, set last=sel, clear cnt and csum, go to GATHER.
  - Arbitration and grant take the same cycle.
- GATHER runs a two-phase cycle:
  - Phase REQ: if have_msg_bus[sel]=1 and cnt<MAX_LEN, assert rdreq_bus[sel] for exactly 1 cycle; otherwise go to SOF.
  - Phase CAP (next cycle): store slave byte into buf[cnt], cnt+=1, csum^=byte, return to REQ.
  - Maximum read rate is one byte per 2 cycles. This allows have_msg to update after the empty flag changes, so an empty source is never read.
- The first REQ in GATHER always reads, since have_msg_bus[sel] was high at grant. Hence len ≥ 1.
- Deassertion of have_msg_bus[sel] is sampled only in REQ.
- have_msg_bus changes on non-selected sources are ignored until the next IDLE.
- SOF / ADDR / LEN / PAYLOAD / CSUM emit, in order:
  - 0xAA
  - {0, sel}
  - cnt
  - buf[0..cnt-1]
  - csum^sel^cnt
- Emission handshake:
  - tx_valid=1 throughout emission; tx_data is registered and stable while tx_valid & !tx_ready.
  - Advance to the next byte only on tx_valid & tx_ready.
  - Zero-bubble: with tx_ready held high, one byte per cycle, so a packet takes len+4 cycles.
- After the CSUM byte is accepted: pkt_done=1 for 1 cycle, tx_valid=0, state=IDLE. A new grant is possible on the next cycle.
- A source with more than MAX_LEN bytes is split into consecutive packets. Other requesting sources are interleaved in between per round-robin.
- tx_ready high outside emission is ignored.
- rst mid-packet: immediate return to reset values. Bytes already read into buf are lost. No partial csum is emitted.
- Width rules:
  - cnt is 8 bits, never exceeding MAX_LEN.
  - sel fits in ceil(log2(N_SRC)) bits, zero-extended to 8 in the addr byte.
  - csum is an 8-bit XOR.

Test Plan:
- Single source, short: source 4 FIFO holds 0x11,0x22,0x33, tx_ready=1 -> rdreq_bus[4] pulses 3 times, 2 cycles apart; tx stream AA 04 03 11 22 33 07; pkt_done pulses once; busy returns low.
- Split: source 1 holds 20 bytes 0x00..0x13, MAX_LEN=16 -> packet AA 01 10 00..0F csum, then AA 01 04 10 11 12 13 csum. Each csum equals the XOR rule.
- Round robin: sources 0 and 3 both request 1 byte continuously from reset -> packet order addr 00, 03, 00, 03; neither starves.
- Backpressure: random tx_ready, including 5-cycle low stretches mid-payload -> tx_data stable while tx_valid & !tx_ready; byte sequence is identical to the tx_ready=1 case; no duplicated or dropped bytes.
- Empty race: source 2 has exactly 1 byte and have_msg drops 1 cycle after rdreq -> exactly one rdreq, len=1, packet AA 02 01 b (2^1^b).
- Reset mid-PAYLOAD: assert rst while byte 2 of 5 is held by tx_ready=0 -> tx_valid=0 and rdreq_bus=0 immediately. After release, with source 0 holding 0x5A and nothing else requesting, the first byte out is 0xAA and the first addr is 00.

Source files
------------

// File: rtl/slave_msg_packer.sv
// Round-robin message packer: drains up to MAX_LEN bytes from one slave source
// and streams them as an AA/addr/len/payload/csum packet over valid/ready.
module slave_msg_packer #(
  parameter int N_SRC   = 5,
  parameter int MAX_LEN = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     have_msg_bus,
  input  logic [8*N_SRC-1:0]   slave_data_bus,
  output logic [N_SRC-1:0]     rdreq_bus,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 pkt_done
);

  localparam int SEL_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int MEM_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [SEL_W-1:0] LAST_INIT = SEL_W'(N_SRC - 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [7:0] SOF_BYTE  = 8'hAA;

  typedef enum logic [2:0] {IDLE, GATHER, SOF, ADDR, LEN, PAYLOAD, CSUM} state_t;

  state_t           state_reg;
  logic             cap_phase_reg;
  logic [SEL_W-1:0] sel_reg;
  logic [SEL_W-1:0] last_reg;
  logic [7:0]       cnt_reg;
  logic [7:0]       idx_reg;
  logic [7:0]       csum_reg;
  logic [7:0]       tx_data_reg;
  logic             tx_valid_reg;

  logic [7:0]       pay_mem [MAX_LEN];

  logic             grant_any;
  logic [SEL_W-1:0] grant_idx;
  logic             read_req;
  logic [7:0]       cur_byte;
  logic [7:0]       addr_byte;
  logic             tx_fire;

  // Search starts just after the last granted source so every requester is
  // eventually served.
  always_comb begin
    int               cand;
    logic [SEL_W-1:0] cand_idx;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = int'(last_reg) + k;
      if (cand >= N_SRC) cand = cand - N_SRC;
      cand_idx = SEL_W'(cand);
      if (!grant_any && have_msg_bus[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // The read strobe is decoded directly from state so the FIFO byte arrives
  // in the very next (capture) cycle.
  assign read_req = (state_reg == GATHER) && !cap_phase_reg &&
                    have_msg_bus[sel_reg] && (cnt_reg < MAX_LEN_B);

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_rdreq
      assign rdreq_bus[gi] = read_req && (sel_reg == SEL_W'(gi));
    end
  endgenerate

  assign cur_byte  = slave_data_bus[{sel_reg, 3'b000} +: 8];
  assign addr_byte = 8'(sel_reg);
  assign tx_fire   = tx_valid_reg && tx_ready;

  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign busy     = (state_reg != IDLE);
  assign pkt_done = (state_reg == CSUM) && tx_fire;

  always_ff @(posedge sys_clk) begin
    if ((state_reg == GATHER) && cap_phase_reg)
      pay_mem[MEM_AW'(cnt_reg)] <= cur_byte;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cap_phase_reg <= 1'b0;
      sel_reg       <= '0;
      last_reg      <= LAST_INIT;
      cnt_reg       <= 8'd0;
      idx_reg       <= 8'd0;
      csum_reg      <= 8'd0;
      tx_data_reg   <= 8'd0;
      tx_valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            sel_reg       <= grant_idx;
            last_reg      <= grant_idx;
            cnt_reg       <= 8'd0;
            csum_reg      <= 8'd0;
            cap_phase_reg <= 1'b0;
            state_reg     <= GATHER;
          end
        end
        GATHER: begin
          if (cap_phase_reg) begin
            csum_reg      <= csum_reg ^ cur_byte;
            cnt_reg       <= cnt_reg + 8'd1;
            cap_phase_reg <= 1'b0;
          end else if (read_req) begin
            cap_phase_reg <= 1'b1;
          end else begin
            tx_data_reg  <= SOF_BYTE;
            tx_valid_reg <= 1'b1;
            state_reg    <= SOF;
          end
        end
        SOF: begin
          if (tx_fire) begin
            tx_data_reg <= addr_byte;
            state_reg   <= ADDR;
          end
        end
        ADDR: begin
          if (tx_fire) begin
            tx_data_reg <= cnt_reg;
            state_reg   <= LEN;
          end
        end
        LEN: begin
          if (tx_fire) begin
            tx_data_reg <= pay_mem[0];
            idx_reg     <= 8'd1;
            state_reg   <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (tx_fire) begin
            if (idx_reg == cnt_reg) begin
              tx_data_reg <= csum_reg ^ addr_byte ^ cnt_reg;
              state_reg   <= CSUM;
            end else begin
              tx_data_reg <= pay_mem[MEM_AW'(idx_reg)];
              idx_reg     <= idx_reg + 8'd1;
            end
          end
        end
        CSUM: begin
          if (tx_fire) begin
            tx_valid_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_msg_packer.sv
// Directed bench for slave_msg_packer: per-source FIFO models feed the DUT and
// a monitor logs every accepted byte, read strobe and packet completion.
module tb_slave_msg_packer;

  localparam int N_SRC = 5;

  logic                 sys_clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N_SRC-1:0]     have_msg_bus;
  logic [8*N_SRC-1:0]   slave_data_bus;
  logic [N_SRC-1:0]     rdreq_bus;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready = 1'b0;
  logic                 busy;
  logic                 pkt_done;

  int checks = 0;
  int errors = 0;

  slave_msg_packer #(.N_SRC(N_SRC), .MAX_LEN(16)) dut (
    .sys_clk(sys_clk), .rst(rst), .have_msg_bus(have_msg_bus),
    .slave_data_bus(slave_data_bus), .rdreq_bus(rdreq_bus), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .pkt_done(pkt_done)
  );

  always #5 sys_clk = ~sys_clk;

  // Non-show-ahead FIFO model per source.
  logic [7:0] fifo_mem [N_SRC][64];
  logic [7:0] fifo_q [N_SRC];
  int wr_ptr [N_SRC] = '{default: 0};
  int rd_ptr [N_SRC] = '{default: 0};
  int empty_reads = 0;

  always @(posedge sys_clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (rdreq_bus[i]) begin
        if (rd_ptr[i] != wr_ptr[i]) begin
          fifo_q[i] <= fifo_mem[i][rd_ptr[i] % 64];
          rd_ptr[i] <= rd_ptr[i] + 1;
        end else begin
          empty_reads <= empty_reads + 1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      have_msg_bus[i] = (rd_ptr[i] != wr_ptr[i]);
      slave_data_bus[8*i +: 8] = fifo_q[i];
    end
  end

  task automatic push(input int s, input logic [7:0] b);
    fifo_mem[s][wr_ptr[s] % 64] = b;
    wr_ptr[s] = wr_ptr[s] + 1;
  endtask

  // Monitor samples on the falling edge, midway between active edges.
  int         cyc = 0;
  int         log_n = 0;
  logic [7:0] log_b [512];
  int         log_c [512];
  int         rd_n = 0;
  int         rd_src [256];
  int         rd_cyc [256];
  int         pkt_cnt = 0;
  int         stab_viol = 0;
  int         multi_rd = 0;
  int         bad_done = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'd0;

  always @(negedge sys_clk) begin
    cyc = cyc + 1;
    if (tx_valid && tx_ready && log_n < 512) begin
      log_b[log_n] = tx_data;
      log_c[log_n] = cyc;
      log_n = log_n + 1;
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (rdreq_bus[i] && rd_n < 256) begin
        rd_src[rd_n] = i;
        rd_cyc[rd_n] = cyc;
        rd_n = rd_n + 1;
      end
    end
    if ($countones(rdreq_bus) > 1) multi_rd = multi_rd + 1;
    if (pkt_done) begin
      if (!(tx_valid && tx_ready && busy)) bad_done = bad_done + 1;
      pkt_cnt = pkt_cnt + 1;
      $display("pkt %0d done at cycle %0d, bytes logged %0d", pkt_cnt, cyc, log_n);
    end
    if (!rst && prev_hold && (!tx_valid || tx_data !== prev_data))
      stab_viol = stab_viol + 1;
    prev_hold = !rst && tx_valid && !tx_ready;
    prev_data = tx_data;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_pkts(input int target, input int budget, input string name);
    int n = 0;
    while (pkt_cnt < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (pkt_cnt < target) begin
      errors++;
      $display("FAIL %s timeout: packets %0d, required %0d", name, pkt_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_ready = 1'b0;
    repeat (3) tick();
    checks++; if (rdreq_bus !== '0) begin errors++; $display("FAIL reset_rdreq got %b want 0", rdreq_bus); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %02h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_pkt_done got %b want 0", pkt_done); end
    rst = 1'b0;
    repeat (2) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [7:0] exp_b [7] = '{8'hAA, 8'h04, 8'h03, 8'h11, 8'h22, 8'h33, 8'h07};
    int s_log = log_n;
    int s_rd  = rd_n;
    int s_pkt = pkt_cnt;
    tx_ready = 1'b1;
    push(4, 8'h11); push(4, 8'h22); push(4, 8'h33);
    wait_pkts(s_pkt + 1, 200, "single");
    checks++; if (log_n - s_log != 7) begin errors++; $display("FAIL single_count got %0d want 7", log_n - s_log); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (log_b[s_log+i] !== exp_b[i]) begin errors++; $display("FAIL single_byte%0d got %02h want %02h", i, log_b[s_log+i], exp_b[i]); end
    end
    checks++; if (rd_n - s_rd != 3) begin errors++; $display("FAIL single_rdreqs got %0d want 3", rd_n - s_rd); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_src[s_rd+i] != 4) begin errors++; $display("FAIL single_rdsrc%0d got %0d want 4", i, rd_src[s_rd+i]); end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (rd_cyc[s_rd+i] - rd_cyc[s_rd+i-1] != 2) begin errors++; $display("FAIL single_rdgap%0d got %0d want 2", i, rd_cyc[s_rd+i] - rd_cyc[s_rd+i-1]); end
    end
    checks++; if (log_c[s_log+6] - log_c[s_log] != 6) begin errors++; $display("FAIL single_bubble got %0d want 6", log_c[s_log+6] - log_c[s_log]); end
    tick();
    checks++; if (pkt_cnt != s_pkt + 1) begin errors++; $display("FAIL single_pktcnt got %0d want %0d", pkt_cnt, s_pkt + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
    $display("test_single done");
  endtask

  task automatic test_split();
    logic [7:0] exp_b [28];
    int s_log = log_n;
    int s_rd  = rd_n;
    int s_pkt = pkt_cnt;
    for (int i = 0; i < 28; i++) begin
      if (i == 0 || i == 20)      exp_b[i] = 8'hAA;
      else if (i == 1 || i == 21) exp_b[i] = 8'h01;
      else if (i == 2)            exp_b[i] = 8'h10;
      else if (i <= 18)           exp_b[i] = 8'(i - 3);
      else if (i == 19)           exp_b[i] = 8'h11;
      else if (i == 22)           exp_b[i] = 8'h04;
      else if (i <= 26)           exp_b[i] = 8'(16 + i - 23);
      else                        exp_b[i] = 8'h05;
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) push(1, 8'(i));
    wait_pkts(s_pkt + 2, 400, "split");
    checks++; if (log_n - s_log != 28) begin errors++; $display("FAIL split_count got %0d want 28", log_n - s_log); end
    for (int i = 0; i < 28; i++) begin
      checks++;
      if (log_b[s_log+i] !== exp_b[i]) begin errors++; $display("FAIL split_byte%0d got %02h want %02h", i, log_b[s_log+i], exp_b[i]); end
    end
    checks++; if (rd_n - s_rd != 20) begin errors++; $display("FAIL split_rdreqs got %0d want 20", rd_n - s_rd); end
    $display("test_split done");
  endtask

  task automatic test_round_robin();
    logic [7:0] pkt0 [5] = '{8'hAA, 8'h00, 8'h01, 8'hA0, 8'hA1};
    logic [7:0] pkt3 [5] = '{8'hAA, 8'h03, 8'h01, 8'hB3, 8'hB1};
    int s_log;
    int s_pkt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    s_log = log_n;
    s_pkt = pkt_cnt;
    push(0, 8'hA0); push(3, 8'hB3);
    for (int p = 0; p < 4; p++) begin
      wait_pkts(s_pkt + p + 1, 200, "rr");
      if (p == 0) push(0, 8'hA0);
      if (p == 1) push(3, 8'hB3);
    end
    checks++; if (log_n - s_log != 20) begin errors++; $display("FAIL rr_count got %0d want 20", log_n - s_log); end
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 5; i++) begin
        logic [7:0] want;
        want = (p % 2 == 0) ? pkt0[i] : pkt3[i];
        checks++;
        if (log_b[s_log+5*p+i] !== want) begin errors++; $display("FAIL rr_pkt%0d_byte%0d got %02h want %02h", p, i, log_b[s_log+5*p+i], want); end
      end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [10] = '{8'hAA, 8'h02, 8'h06, 8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'hFB};
    int  s_log = log_n;
    int  s_pkt = pkt_cnt;
    int  s_viol = stab_viol;
    int  n = 0;
    bit  stretched = 1'b0;
    push(2, 8'h3C); push(2, 8'hC3); push(2, 8'h5A);
    push(2, 8'hA5); push(2, 8'h0F); push(2, 8'hF0);
    while (pkt_cnt < s_pkt + 1 && n < 600) begin
      if (!stretched && log_n - s_log == 5) begin
        tx_ready = 1'b0;
        repeat (5) tick();
        stretched = 1'b1;
        n += 5;
      end else begin
        tx_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
    end
    tx_ready = 1'b1;
    checks++; if (pkt_cnt < s_pkt + 1) begin errors++; $display("FAIL bp timeout: packets %0d, required %0d", pkt_cnt, s_pkt + 1); end
    checks++; if (!stretched) begin errors++; $display("FAIL bp_stretch got 0 want 1"); end
    checks++; if (log_n - s_log != 10) begin errors++; $display("FAIL bp_count got %0d want 10", log_n - s_log); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (log_b[s_log+i] !== exp_b[i]) begin errors++; $display("FAIL bp_byte%0d got %02h want %02h", i, log_b[s_log+i], exp_b[i]); end
    end
    checks++; if (stab_viol != s_viol) begin errors++; $display("FAIL bp_stable got %0d violations want 0", stab_viol - s_viol); end
    $display("test_backpressure done");
  endtask

  task automatic test_empty_race();
    logic [7:0] exp_b [5] = '{8'hAA, 8'h02, 8'h01, 8'h6D, 8'h6E};
    int s_log = log_n;
    int s_rd  = rd_n;
    int s_pkt = pkt_cnt;
    tx_ready = 1'b1;
    push(2, 8'h6D);
    wait_pkts(s_pkt + 1, 200, "empty");
    checks++; if (rd_n - s_rd != 1) begin errors++; $display("FAIL empty_rdreqs got %0d want 1", rd_n - s_rd); end
    checks++; if (log_n - s_log != 5) begin errors++; $display("FAIL empty_count got %0d want 5", log_n - s_log); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_b[s_log+i] !== exp_b[i]) begin errors++; $display("FAIL empty_byte%0d got %02h want %02h", i, log_b[s_log+i], exp_b[i]); end
    end
    $display("test_empty_race done");
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_b [5] = '{8'hAA, 8'h00, 8'h01, 8'h5A, 8'h5B};
    int s_log = log_n;
    int s_pkt;
    int n = 0;
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(1, 8'(8'h10 + i));
    while (log_n - s_log < 5 && n < 200) begin
      tick();
      n++;
    end
    tx_ready = 1'b0;
    checks++; if (log_n - s_log != 5) begin errors++; $display("FAIL rmid_reach got %0d bytes want 5", log_n - s_log); end
    repeat (2) tick();
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL rmid_hold_valid got %b want 1", tx_valid); end
    checks++; if (tx_data !== 8'h12) begin errors++; $display("FAIL rmid_hold_data got %02h want 12", tx_data); end
    rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", tx_valid); end
    checks++; if (rdreq_bus !== '0) begin errors++; $display("FAIL rmid_rdreq got %b want 0", rdreq_bus); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    s_log = log_n;
    s_pkt = pkt_cnt;
    push(0, 8'h5A);
    wait_pkts(s_pkt + 1, 200, "rmid_after");
    checks++; if (log_n - s_log != 5) begin errors++; $display("FAIL rmid_count got %0d want 5", log_n - s_log); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_b[s_log+i] !== exp_b[i]) begin errors++; $display("FAIL rmid_byte%0d got %02h want %02h", i, log_b[s_log+i], exp_b[i]); end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_invariants();
    checks++; if (empty_reads != 0) begin errors++; $display("FAIL inv_empty_reads got %0d want 0", empty_reads); end
    checks++; if (multi_rd != 0) begin errors++; $display("FAIL inv_onehot got %0d want 0", multi_rd); end
    checks++; if (bad_done != 0) begin errors++; $display("FAIL inv_pkt_done got %0d want 0", bad_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_split();
    test_round_robin();
    test_backpressure();
    test_empty_race();
    test_reset_mid();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
